// File: rtl/oprd_fetch_pkg.sv
// Shared encodings for the operand fetch stage: addressing modes (also used by
// the instruction decoder) and the fetch FSM state.
package oprd_fetch_pkg;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'b00,
    MODE_DIR  = 2'b01,
    MODE_RIND = 2'b10,
    MODE_MIND = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PTR  = 3'd1,
    S_RD   = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/oprd_fetch_mem_wait_timer.sv
// Wait counter for one memory read: clears on request entry, counts cycles
// without ack, and flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !expired)
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/oprd_fetch.sv
// Operand fetch stage: resolves an operand byte by addressing mode, runs the
// req/ack read handshake with a per-read timeout, and emits a registered operand.
module oprd_fetch
  import oprd_fetch_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] reg_val,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] oprd,
  output logic              oprd_valid,
  output logic              busy,
  output logic              err
);

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   oprd_q, oprd_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                tmr_clr, tmr_en, tmr_expired;

  // Truncates or zero-extends a data byte to the address width.
  function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] v);
    logic [ADDR_W+DATA_W-1:0] wide;
    wide = {{ADDR_W{1'b0}}, v};
    return wide[ADDR_W-1:0];
  endfunction

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    oprd_d     = oprd_q;
    tmr_clr    = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_clr = 1'b1;
        if (start) begin
          case (mode_e'(mode))
            MODE_IMM:  begin oprd_d = imm;                 state_d = S_DONE; end
            MODE_DIR:  begin mem_addr_d = to_addr(imm);     state_d = S_RD;   end
            MODE_RIND: begin mem_addr_d = to_addr(reg_val); state_d = S_RD;   end
            default:   begin mem_addr_d = to_addr(imm);     state_d = S_PTR;  end
          endcase
        end
      end
      S_PTR: begin
        // Pointer read: the returned byte becomes the operand address.
        if (mem_ack) begin
          mem_addr_d = to_addr(mem_rdata);
          tmr_clr    = 1'b1;
          state_d    = S_RD;
        end else if (tmr_expired) begin
          oprd_d  = '0;
          state_d = S_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      S_RD: begin
        if (mem_ack) begin
          oprd_d  = mem_rdata;
          state_d = S_DONE;
        end else if (tmr_expired) begin
          oprd_d  = '0;
          state_d = S_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_req_d = (state_d == S_PTR) || (state_d == S_RD);
    valid_d   = (state_d == S_DONE);
    err_d     = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      oprd_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      oprd_q     <= oprd_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign oprd       = oprd_q;
  assign oprd_valid = valid_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_oprd_fetch.sv
// Scoreboard bench for oprd_fetch: expected results are queued at stimulus time
// and matched (value, kind, latency) whenever the DUT strobes valid or err.
module tb_oprd_fetch;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  typedef struct {
    bit              is_err;
    logic [DATA_W-1:0] data;
    int              k;
    int              lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [DATA_W-1:0] imm, reg_val;
  logic              mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, oprd;
  logic              oprd_valid, busy, err;

  exp_t              sb[$];
  logic [ADDR_W-1:0] acc_addr[$];
  logic [DATA_W-1:0] mem [256];
  int checks = 0, errors = 0, cyc = 0;
  int valid_cnt = 0, err_cnt = 0, req_cnt = 0;
  int wait_cycles = 0;
  bit resp_en = 1'b1, spurious = 1'b0;

  oprd_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .imm(imm), .reg_val(reg_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .oprd(oprd), .oprd_valid(oprd_valid), .busy(busy), .err(err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  // Memory responder: acks after wait_cycles request cycles without ack.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && resp_en) begin
        if (wcnt >= wait_cycles) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          acc_addr.push_back(mem_addr);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = spurious;
        mem_rdata = 8'hEE;
        wcnt = 0;
      end
    end
  end

  // Output monitor: pops the scoreboard on every valid or err strobe.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_req) req_cnt++;
      if (oprd_valid || err) begin
        if (oprd_valid) valid_cnt++;
        if (err) err_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: valid=%0b err=%0b oprd=%h, required no output", oprd_valid, err, oprd);
        end else begin
          e = sb.pop_front();
          if (err !== e.is_err || oprd_valid !== !e.is_err) begin
            errors++;
            $display("FAIL out_kind: err=%0b valid=%0b, required err=%0b", err, oprd_valid, e.is_err);
          end
          checks++;
          if (oprd !== e.data) begin
            errors++;
            $display("FAIL out_data: oprd=%h, required %h", oprd, e.data);
          end
          checks++;
          if (cyc - e.k != e.lat) begin
            errors++;
            $display("FAIL out_latency: %0d edges, required %0d", cyc - e.k, e.lat);
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [7:0] i, input logic [7:0] r,
                       input bit push, input bit is_err, input logic [7:0] d, input int lat);
    @(negedge clk);
    start = 1'b1; mode = m; imm = i; reg_val = r;
    if (push) sb.push_back('{is_err, d, cyc + 1, lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL wait_done: still busy=%0b pending=%0d after %0d cycles, required idle", busy, sb.size(), budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_delta(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: %0d, required %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, mem_addr, oprd, oprd_valid, busy, err} !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%0b addr=%h oprd=%h valid=%0b busy=%0b err=%0b, required all 0",
               mem_req, mem_addr, oprd, oprd_valid, busy, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_immediate();
    int v0, r0;
    v0 = valid_cnt; r0 = req_cnt;
    issue(2'b00, 8'hA5, 8'h00, 1'b1, 1'b0, 8'hA5, 0);
    wait_done(20);
    check_delta("imm_valid_count", valid_cnt - v0, 1);
    check_delta("imm_req_cycles", req_cnt - r0, 0);
    check_delta("imm_oprd_hold", int'(oprd), 8'hA5);
  endtask

  task automatic test_direct_wait();
    int v0;
    v0 = valid_cnt;
    wait_cycles = 3;
    mem[8'h3C] = 8'h7E;
    acc_addr.delete();
    issue(2'b01, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h7E, 4);
    @(negedge clk);
    start = 1'b1; mode = 2'b00; imm = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    check_delta("dir_acc_count", acc_addr.size(), 1);
    if (acc_addr.size() > 0) check_delta("dir_addr", int'(acc_addr[0]), 8'h3C);
    check_delta("dir_valid_count", valid_cnt - v0, 1);
    check_delta("dir_oprd", int'(oprd), 8'h7E);
    wait_cycles = 0;
  endtask

  task automatic test_mem_indirect();
    int r0;
    r0 = req_cnt;
    mem[8'h10] = 8'h44;
    mem[8'h44] = 8'h9B;
    acc_addr.delete();
    issue(2'b11, 8'h10, 8'h00, 1'b1, 1'b0, 8'h9B, 2);
    wait_done(40);
    check_delta("mind_acc_count", acc_addr.size(), 2);
    if (acc_addr.size() == 2) begin
      check_delta("mind_ptr_addr", int'(acc_addr[0]), 8'h10);
      check_delta("mind_data_addr", int'(acc_addr[1]), 8'h44);
    end
    check_delta("mind_req_cycles", req_cnt - r0, 2);
  endtask

  task automatic test_timeout();
    int v0, e0, r0;
    v0 = valid_cnt; e0 = err_cnt; r0 = req_cnt;
    resp_en = 1'b0;
    issue(2'b10, 8'h00, 8'h20, 1'b1, 1'b1, 8'h00, TIMEOUT);
    wait_done(100);
    check_delta("to_err_count", err_cnt - e0, 1);
    check_delta("to_valid_count", valid_cnt - v0, 0);
    check_delta("to_req_cycles", req_cnt - r0, TIMEOUT);
    check_delta("to_mem_req", int'(mem_req), 0);
    check_delta("to_addr", int'(mem_addr), 8'h20);
    check_delta("to_oprd", int'(oprd), 8'h00);
    resp_en = 1'b1;
  endtask

  task automatic test_ack_final();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    wait_cycles = TIMEOUT - 1;
    mem[8'h20] = 8'h55;
    issue(2'b10, 8'h00, 8'h20, 1'b1, 1'b0, 8'h55, TIMEOUT);
    wait_done(100);
    check_delta("final_err_count", err_cnt - e0, 0);
    check_delta("final_valid_count", valid_cnt - v0, 1);
    check_delta("final_oprd", int'(oprd), 8'h55);
    wait_cycles = 0;
  endtask

  task automatic test_spurious_ack();
    int v0, e0, r0;
    v0 = valid_cnt; e0 = err_cnt; r0 = req_cnt;
    spurious = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_delta("spur_busy", int'(busy), 0);
    end
    spurious = 1'b0;
    @(negedge clk);
    check_delta("spur_req_cycles", req_cnt - r0, 0);
    check_delta("spur_outputs", (valid_cnt - v0) + (err_cnt - e0), 0);
    check_delta("spur_oprd", int'(oprd), 8'h55);
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = valid_cnt;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; imm = 8'h11;
    sb.push_back('{1'b0, 8'h11, cyc + 1, 0});
    @(negedge clk);
    imm = 8'h22;
    sb.push_back('{1'b0, 8'h22, cyc + 2, 0});
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    check_delta("b2b_valid_count", valid_cnt - v0, 2);
  endtask

  task automatic test_reset_mid_rd();
    int v0, e0;
    resp_en = 1'b0;
    issue(2'b01, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 0);
    repeat (2) @(negedge clk);
    check_delta("rst_pre_req", int'(mem_req), 1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, oprd, oprd_valid, busy, err} !== '0) begin
      errors++;
      $display("FAIL async_reset: req=%0b oprd=%h valid=%0b busy=%0b err=%0b, required all 0",
               mem_req, oprd, oprd_valid, busy, err);
    end
    v0 = valid_cnt; e0 = err_cnt;
    @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    repeat (6) @(negedge clk);
    check_delta("rst_no_stale_out", (valid_cnt - v0) + (err_cnt - e0), 0);
    check_delta("rst_idle", int'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
    rst = 1'b1; start = 1'b0; mode = 2'b00; imm = '0; reg_val = '0;
    test_reset();
    test_immediate();
    test_direct_wait();
    test_mem_indirect();
    test_timeout();
    test_ack_final();
    test_spurious_ack();
    test_back_to_back();
    test_reset_mid_rd();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
